// File: rtl/sccb_responder.sv
// SCCB/I2C-style target emulating the OV7670 control port: 3-phase writes,
// 2-phase write + read, 256x8 register file, oversampled sioc/siod.
module sccb_responder #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter bit         ACK_EN      = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sioc,
  input  logic        siod_i,
  output logic        siod_oe,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] write_count,
  output logic        busy,
  input  logic [7:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [3:0]  dbg_state
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUBADDR, S_SUBADDR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_MACK, S_IGNORE
  } state_t;

  // Bus handshake: bits are taken on the synced sioc rising edge; siod_oe only
  // moves on the synced sioc falling edge, so siod never changes while sioc is high.
  logic [SS-1:0] scl_sync_q, sda_sync_q;
  logic          scl_prev_q, sda_prev_q;
  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall, start_det, stop_det;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          ackph_q, ackph_d;
  logic          wr_valid_q, wr_valid_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic          mem_we;
  logic [7:0]    mem_q [256];
  logic [7:0]    byte_in;
  logic [2:0]    bit_idx;

  assign scl_s     = scl_sync_q[SS-1];
  assign sda_s     = sda_sync_q[SS-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in   = {shreg_q[6:0], sda_s};
  assign bit_idx   = 3'd7 - cnt_q[2:0];

  // Synchronizers reset to the idle-bus level so reset release is never seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SS-2:0], sioc};
      sda_sync_q <= {sda_sync_q[SS-2:0], siod_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    ackph_d    = ackph_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wcnt_d     = wcnt_q;
    mem_we     = 1'b0;

    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      ackph_d = 1'b0;
    end else if (start_det) begin
      // Repeated start keeps the pointer for the write-then-read sequence.
      state_d = S_ID;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
      ackph_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ID, S_SUBADDR, S_WDATA: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == S_ID) begin
                rw_d    = byte_in[0];
                state_d = (byte_in[7:1] == DEV_ID[7:1]) ? S_ID_ACK : S_IGNORE;
              end else if (state_q == S_SUBADDR) begin
                ptr_d   = byte_in;
                state_d = S_SUBADDR_ACK;
              end else begin
                mem_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                wcnt_d     = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
                ptr_d      = ptr_q + 8'd1;
                state_d    = S_WDATA_ACK;
              end
            end
          end
        end
        S_ID_ACK, S_SUBADDR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ackph_q) begin
              oe_d    = ACK_EN;
              ackph_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              ackph_d = 1'b0;
              if (state_q != S_ID_ACK) begin
                state_d = S_WDATA;
              end else if (rw_q) begin
                // The ACK release edge is also where the first read bit goes out.
                oe_d    = ~mem_q[ptr_q][7];
                cnt_d   = 4'd1;
                state_d = S_RDATA;
              end else begin
                state_d = S_SUBADDR;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              ptr_d   = ptr_q + 8'd1;
              state_d = S_RD_MACK;
            end else begin
              oe_d  = ~mem_q[ptr_q][bit_idx];
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_RD_MACK: begin
          if (scl_rise) begin
            cnt_d   = 4'd0;
            state_d = sda_s ? S_IGNORE : S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shreg_q    <= 8'h00;
      ptr_q      <= 8'h00;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      ackph_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      wcnt_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      ackph_q    <= ackph_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wcnt_q     <= wcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[ptr_q] <= byte_in;
    end
  end

  assign siod_oe     = oe_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign write_count = wcnt_q;
  assign busy        = busy_q;
  assign dbg_data    = mem_q[dbg_addr];
  assign dbg_state   = state_q;

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB/I2C-style target (responder) that emulates the OV7670 control port for simulation and in-FPGA loopback of the camera configuration path.
- Receives 3-phase write transactions (ID, sub-address, data) and 2-phase write + read transactions from the camera controller's serial master.
- Stores written values in an internal 256x8 register file and reports each write on a one-cycle strobe.
- Oversamples `sioc`/`siod` in the system clock domain; `siod` is open-drain (pull-down only).

Parameters:
- DEV_ID, 8'h42, device write ID; bit0 is ignored when matching and is taken as R/W (0 = write, 1 = read).
- ACK_EN, 1, 1: drive ACK low on matched ID/sub-address/data bytes; 0: leave the 9th bit released (SCCB don't-care).
- SYNC_STAGES, 2, synchronizer depth on `sioc` and `siod_i` (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the `sioc` rate.
- rst_n  input  1  asynchronous active-low reset.
- sioc  input  1  serial clock from master.
- siod_i  input  1  sampled level of the shared `siod` line.
- siod_oe  output  1  1 = pull `siod` low; 0 = release (high-Z).
- wr_valid  output  1  one-cycle pulse per accepted data write.
- wr_addr  output  8  register address of the write; valid with `wr_valid`.
- wr_data  output  8  data byte of the write; valid with `wr_valid`.
- write_count  output  16  number of accepted writes; saturates at 16'hFFFF.
- busy  output  1  high from START until STOP.
- dbg_addr  input  8  backdoor read address.
- dbg_data  output  8  register-file contents at `dbg_addr` (combinational).

Behaviour:
- Reset: `siod_oe`=0, `wr_valid`=0, `wr_addr`/`wr_data`=0, `write_count`=0, `busy`=0, all register-file entries=8'h00, pointer=0, FSM=IDLE.
- Input synchronization: `sioc` and `siod_i` each pass through SYNC_STAGES flops; all edge detection uses the synchronized values.
- START: synced `siod` falls while synced `sioc` is high.
- STOP: synced `siod` rises while synced `sioc` is high.
- Bits are sampled on the synced `sioc` rising edge, MSB first. `siod_oe` changes only on the synced `sioc` falling edge.
- FSM states: IDLE, ID, ID_ACK, SUBADDR, SUBADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
- IDLE: START -> ID with `busy`=1 and bit counter cleared.
- ID: after 8 bits, compare byte[7:1] with DEV_ID[7:1].
  - Match -> ID_ACK.
  - Mismatch -> IGNORE; `siod_oe` stays 0 until STOP.
- ID_ACK: at the next falling edge, `siod_oe`=ACK_EN; release at the following falling edge. Then go to SUBADDR if R/W=0, or RDATA if R/W=1.
- SUBADDR: 8 bits load the pointer -> SUBADDR_ACK (same ACK rule) -> WDATA.
- WDATA: after 8 bits:
  - reg[pointer] <= byte.
  - `wr_valid`=1 for one clk, with `wr_addr`=pointer and `wr_data`=byte, in the cycle after the 8th rising-edge detect.
  - `write_count` increments (saturating).
  - pointer increments, wrapping 8'hFF -> 8'h00.
  - Go to WDATA_ACK (same ACK rule), then back to WDATA for further bytes.
- RDATA:
  - On each falling edge, drive `siod_oe` = ~bit of reg[pointer], MSB first.
  - After the 8th bit, release at the falling edge -> RD_MACK.
  - Pointer increments (wrapping) after each byte is sent.
- RD_MACK: sample master bit on the rising edge.
  - 0 (ACK) -> RDATA with the next byte.
  - 1 (NACK) -> IGNORE.
- STOP in any state: FSM=IDLE, `siod_oe`=0, `busy`=0. A partial byte is discarded. A transaction that ends after SUBADDR sets the pointer only (no `wr_valid`).
- START while `busy` (repeated start): go to ID, clear bit counter, `siod_oe`=0. The pointer is retained, enabling the 2-phase write then read sequence.
- Simultaneous WDATA completion and `dbg_addr` equal to the target address: `dbg_data` shows the old value until the cycle of `wr_valid`, then the new value.
- Reset asserted mid-transaction: immediate return to reset state, bus released.
- `siod` activity while `sioc` is low is not START/STOP; it is ignored except as data setup.

Test Plan:
- 3-phase write ID 0x42, sub 0x12, data 0x80 -> ACK low on all three 9th bits; one `wr_valid` with `wr_addr`=0x12, `wr_data`=0x80; `write_count`=1; `dbg_addr`=0x12 gives 0x80.
- Write ID 0x60 (mismatch) + 2 bytes -> `siod_oe` never asserted, no `wr_valid`, `busy` low after STOP, register file unchanged.
- Write sub 0xFF with data 0xA5, 0x5A in one transaction -> reg[0xFF]=0xA5, reg[0x00]=0x5A, two strobes, `write_count`=2.
- 2-phase write sub 0x12, STOP, START, ID 0x43, master NACK -> `siod` carries 0x80 MSB first; `siod_oe` released after bit 0; FSM IDLE after STOP.
- Repeated START after sub 0x0A, then ID 0x43, master ACK then NACK -> returns reg[0x0A] then reg[0x0B].
- Assert `rst_n`=0 during WDATA bit 4 -> all outputs zero within the same cycle; next transaction with sub 0x01, data 0x33 succeeds normally.
